// File: rtl/shift_sched.sv
// -----------------------------------------------------------------------------
// shift_sched
//
// Shares one bidirectional serial-in shift-register chain between two
// requesters. A word accepted from port A is shifted in MSB first through the
// chain's left serial input (chain shifting towards higher stages). A word
// accepted from port B is shifted in LSB first through the right serial input
// (chain shifting towards lower stages). Either way the chain ends up holding
// the word in natural bit order. One cycle later the parallel chain output is
// captured and returned with a one-cycle strobe and the source port tag.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   a_valid/a_ready/a_data   port A word handshake
//   b_valid/b_ready/b_data   port B word handshake
//   sr_left_in   chain left serial input (enters stage 0)
//   sr_right_in  chain right serial input (enters stage DATA_WIDTH-1)
//   sr_shift_lr  chain direction, 0 = towards higher stages, 1 = towards lower
//   sr_q         chain parallel output
//   busy         high while a transfer is in flight (SHIFT or DONE)
//   res_valid    one-cycle result strobe, no backpressure
//   res_data     captured chain word
//   res_src      source of the result, 0 = port A, 1 = port B
//
// Handshake: a word transfers on the rising edge where x_valid & x_ready are
// both high. Ready is only ever raised in IDLE with rst low, for the single
// port chosen by the round-robin arbiter, so at most one ready is high at a
// time. Ready depends combinationally on valid; valid must not depend on ready.
// -----------------------------------------------------------------------------
module shift_sched #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  sr_left_in,
    output logic                  sr_right_in,
    output logic                  sr_shift_lr,
    input  logic [DATA_WIDTH-1:0] sr_q,
    output logic                  busy,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_src
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  last_grant_q, last_grant_d;  // 0 = A, 1 = B
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  src_q, src_d;                // 0 = A, 1 = B
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_src_q, res_src_d;

    logic                  grant_b;
    logic [CW-1:0]         idx_msb;

    // Bit index for MSB-first serialisation on port A.
    assign idx_msb = COUNT_LAST - count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            word_q       <= '0;
            src_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            src_q        <= src_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_src_q    <= res_src_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        src_d        = src_q;
        res_valid_d  = 1'b0;
        res_data_d   = res_data_q;
        res_src_d    = res_src_q;
        a_ready      = 1'b0;
        b_ready      = 1'b0;

        // B wins when it is alone, or when both ask and A was served last.
        grant_b = b_valid && (!a_valid || !last_grant_q);

        case (state_q)
            IDLE: begin
                a_ready = !rst && a_valid && !grant_b;
                b_ready = !rst && grant_b;
                if (a_valid || b_valid) begin
                    word_d       = grant_b ? b_data : a_data;
                    src_d        = grant_b;
                    last_grant_d = grant_b;
                    count_d      = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == COUNT_LAST) begin
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                res_data_d  = sr_q;
                res_src_d   = src_q;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial outputs are decoded from registered state only, so they are
    // stable from the start of each shift cycle. The direction is the source
    // register, which naturally holds its last value in IDLE and DONE.
    assign sr_left_in  = (state_q == SHIFT) && !src_q && word_q[idx_msb];
    assign sr_right_in = (state_q == SHIFT) && src_q && word_q[count_q];
    assign sr_shift_lr = src_q;

    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_src   = res_src_q;

endmodule

// File: tb/tb_shift_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_sched
//
// Directed bench for shift_sched with DATA_WIDTH = 8. A behavioural model of
// the shared shift chain closes the loop from the serial outputs back to sr_q.
// Inputs are driven 1 time unit after each rising edge and outputs are sampled
// 2 time units after it.
// -----------------------------------------------------------------------------
module tb_shift_sched;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [DW-1:0] a_data, b_data;
    logic          sr_left_in, sr_right_in, sr_shift_lr;
    logic [DW-1:0] sr_q;
    logic          busy, res_valid, res_src;
    logic [DW-1:0] res_data;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int last_res_cyc = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shift chain model ----------------
    logic [DW-1:0] chain = '0;
    always_ff @(posedge clk) begin
        if (sr_shift_lr)
            chain <= {sr_right_in, chain[DW-1:1]};
        else
            chain <= {chain[DW-2:0], sr_left_in};
    end
    assign sr_q = chain;

    shift_sched #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_data      (b_data),
        .sr_left_in  (sr_left_in),
        .sr_right_in (sr_right_in),
        .sr_shift_lr (sr_shift_lr),
        .sr_q        (sr_q),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_src     (res_src)
    );

    // ---------------- checkers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Move to the drive point of the next cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer, entered and left at the drive point of an IDLE
    // cycle. seq lists the expected serial bits left to right (shift cycle 0
    // first). keep leaves valid high after accept. At shift cycle inj_k port B
    // starts requesting inj_data. gap_chk compares the result spacing against
    // the previous result.
    task automatic run_word(input logic port, input logic [DW-1:0] data,
                            input logic [DW-1:0] seq, input logic keep,
                            input int inj_k, input logic [DW-1:0] inj_data,
                            input logic gap_chk);
        int acc_cyc;
        if (!port) begin a_valid = 1'b1; a_data = data; end
        else       begin b_valid = 1'b1; b_data = data; end
        #1;
        chk1("accept_ready", port ? b_ready : a_ready, 1'b1);
        chk1("accept_other_ready", port ? a_ready : b_ready, 1'b0);
        acc_cyc = cyc;
        for (int k = 0; k < DW; k++) begin
            next_cycle();
            if (!keep) begin
                if (!port) a_valid = 1'b0;
                else       b_valid = 1'b0;
            end
            if (k == inj_k) begin
                b_valid = 1'b1;
                b_data  = inj_data;
            end
            #1;
            chk1("shift_dir", sr_shift_lr, port);
            chk1("shift_bit", port ? sr_right_in : sr_left_in, seq[DW-1-k]);
            chk1("shift_unused_in", port ? sr_left_in : sr_right_in, 1'b0);
            chk1("shift_a_ready", a_ready, 1'b0);
            chk1("shift_b_ready", b_ready, 1'b0);
            chk1("shift_busy", busy, 1'b1);
            chk1("shift_res_valid", res_valid, 1'b0);
        end
        next_cycle();
        #1;
        chk1("done_busy", busy, 1'b1);
        chk1("done_res_valid", res_valid, 1'b0);
        chk8("done_chain", sr_q, data);
        chk1("done_left_in", sr_left_in, 1'b0);
        chk1("done_right_in", sr_right_in, 1'b0);
        chk1("done_dir_hold", sr_shift_lr, port);
        next_cycle();
        #1;
        chk1("res_valid", res_valid, 1'b1);
        chk8("res_data", res_data, data);
        chk1("res_src", res_src, port);
        chk1("res_busy", busy, 1'b0);
        chki("res_latency", cyc - acc_cyc, DW + 2);
        if (gap_chk) chki("res_spacing", cyc - last_res_cyc, DW + 2);
        last_res_cyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0;
        next_cycle();
        next_cycle();

        // Reset state, with both requesters asking while rst is high.
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk1("rst_a_ready", a_ready, 1'b0);
        chk1("rst_b_ready", b_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk8("rst_res_data", res_data, 8'h00);
        chk1("rst_res_src", res_src, 1'b0);
        chk1("rst_left_in", sr_left_in, 1'b0);
        chk1("rst_right_in", sr_right_in, 1'b0);
        chk1("rst_dir", sr_shift_lr, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        next_cycle();
        rst = 1'b0;

        // Single A word: serial 1,0,1,1,0,1,0,0.
        run_word(1'b0, 8'hB4, 8'b1011_0100, 1'b0, -1, 8'h00, 1'b0);
        // Single B word: serial 0,0,1,1,1,1,0,0.
        run_word(1'b1, 8'h3C, 8'b0011_1100, 1'b0, -1, 8'h00, 1'b0);

        // Both requesting continuously from reset: A,B,A,B.
        do_reset();
        a_valid = 1'b1; a_data = 8'h11;
        b_valid = 1'b1; b_data = 8'h22;
        run_word(1'b0, 8'h11, 8'b0001_0001, 1'b1, -1, 8'h00, 1'b0);
        run_word(1'b1, 8'h22, 8'b0100_0100, 1'b1, -1, 8'h00, 1'b1);
        run_word(1'b0, 8'h11, 8'b0001_0001, 1'b1, -1, 8'h00, 1'b1);
        run_word(1'b1, 8'h22, 8'b0100_0100, 1'b1, -1, 8'h00, 1'b1);
        a_valid = 1'b0; b_valid = 1'b0;

        // A only, back to back.
        run_word(1'b0, 8'h01, 8'b0000_0001, 1'b0, -1, 8'h00, 1'b0);
        run_word(1'b0, 8'h80, 8'b1000_0000, 1'b0, -1, 8'h00, 1'b1);
        run_word(1'b0, 8'hFF, 8'b1111_1111, 1'b0, -1, 8'h00, 1'b1);

        // Reset during the 4th shift cycle of A = 0x5A.
        a_valid = 1'b1; a_data = 8'h5A;
        #1;
        chk1("abort_accept", a_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            a_valid = 1'b0;
            if (k == 3) begin
                rst = 1'b1;
                a_valid = 1'b1;
                #1;
                chk1("abort_rst_a_ready", a_ready, 1'b0);
            end
        end
        next_cycle();
        rst = 1'b0;
        a_valid = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_res_valid", res_valid, 1'b0);
        chk1("abort_dir", sr_shift_lr, 1'b0);
        // The following B word is granted in this very cycle.
        run_word(1'b1, 8'hA5, 8'b1010_0101, 1'b0, -1, 8'h00, 1'b0);

        // B arrives mid A transfer and waits for IDLE.
        run_word(1'b0, 8'hC3, 8'b1100_0011, 1'b0, 2, 8'h96, 1'b0);
        run_word(1'b1, 8'h96, 8'b0110_1001, 1'b0, -1, 8'h00, 1'b1);

        next_cycle();
        #1;
        chk1("final_res_valid", res_valid, 1'b0);
        chk1("final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
# shift_sched

Two-port scheduler that shares one bidirectional serial-in shift-register chain (DATA_WIDTH stages, shifting every clock) between two requesters. Port A loads words through the chain's left serial input; port B loads words through its right serial input. Each accepted word is serialized into the chain over DATA_WIDTH cycles. The parallel chain output is then captured and returned as a result tagged with the source port. The block sits directly in front of the shift chain and is its only driver of direction and serial data.

## Interface
Parameters:
- DATA_WIDTH, 8, word width and chain length in stages; legal range ≥ 2.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  port A word available.
- a_ready  out  1  port A accepted on the rising edge where a_valid & a_ready.
- a_data  in  DATA_WIDTH  port A word.
- b_valid  in  1  port B word available.
- b_ready  out  1  port B accept, same rule as port A.
- b_data  in  DATA_WIDTH  port B word.
- sr_left_in  out  1  to chain left serial input (enters stage 0).
- sr_right_in  out  1  to chain right serial input (enters stage DATA_WIDTH-1).
- sr_shift_lr  out  1  chain direction. 0: stage i loads stage i-1, with stage 0 loading sr_left_in. 1: stage i loads stage i+1, with stage DATA_WIDTH-1 loading sr_right_in.
- sr_q  in  DATA_WIDTH  chain parallel output.
- busy  out  1  high in SHIFT or DONE.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  DATA_WIDTH  captured chain word.
- res_src  out  1  0 = port A, 1 = port B.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: IDLE, count 0, last_grant = B, res_valid 0, res_data 0, res_src 0, sr_left_in 0, sr_right_in 0, sr_shift_lr 0, busy 0.
- IDLE, arbitration:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port that is not last_grant (round-robin).
- Ready signals:
  - Only the granted port's ready is high; at most one ready is high in any cycle.
  - Both readys are 0 outside IDLE and whenever rst is high.
- On accept:
  - Latch the word into a holding register.
  - Latch the source port and set last_grant to it.
  - Clear count and go to SHIFT.
- SHIFT, port A:
  - sr_shift_lr = 0.
  - In shift cycle k (k = 0..DATA_WIDTH-1), sr_left_in = word[DATA_WIDTH-1-k], i.e. MSB first.
  - sr_right_in = 0.
- SHIFT, port B:
  - sr_shift_lr = 1.
  - In shift cycle k, sr_right_in = word[k], i.e. LSB first.
  - sr_left_in = 0.
- SHIFT exit: count increments every cycle. After the cycle with count = DATA_WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - sr_q equals the transferred word.
  - Register res_data ← sr_q, res_src ← source, res_valid ← 1; the strobe appears in the following cycle.
  - Then return to IDLE.
- Serial data in IDLE and DONE: sr_left_in and sr_right_in are 0, and sr_shift_lr holds its last value. The chain keeps shifting; its contents are don't-care outside a transfer.
- res_valid: high for exactly one cycle per completed transfer. There is no backpressure on the result.
- Count register width: $clog2(DATA_WIDTH). Count never exceeds DATA_WIDTH-1.

## Timing
- Accept edge E0.
- Shift cycles are the cycles following E0 through E_DATA_WIDTH; each is sampled by the chain on its closing edge.
- DONE is the cycle after E_DATA_WIDTH.
- res_valid is high in the cycle after DONE, i.e. DATA_WIDTH+2 cycles after the accept cycle.
- A next accept is possible in that same cycle (IDLE), so peak throughput is one word per DATA_WIDTH+2 cycles.
- sr_* outputs for shift cycle k are stable by the start of that cycle: registered, or decoded from registered state only.
- rst mid-operation (SHIFT or DONE):
  - Abort without a result; res_valid stays 0.
  - Return to IDLE with reset values; the held word is discarded.
  - Ready may assert in the first cycle after rst deasserts.
- A valid deasserting while the block is not in IDLE has no effect; only accept edges matter.
- Valid held high during SHIFT is not accepted until the next IDLE.

## Test plan
- Port A single word, DATA_WIDTH=8, a_data=0xB4:
  - sr_left_in sequence is 1,0,1,1,0,1,0,0 with sr_shift_lr=0.
  - res_valid is high 10 cycles after the accept cycle, with res_data=0xB4 and res_src=0.
- Port B single word, b_data=0x3C:
  - sr_right_in sequence is 0,0,1,1,1,1,0,0 with sr_shift_lr=1.
  - res_data=0x3C, res_src=1.
- Both ports valid continuously from reset, A=0x11, B=0x22:
  - Grants alternate A,B,A,B.
  - Results arrive as 0x11,0x22,0x11,0x22, spaced 10 cycles apart.
  - a_ready and b_ready are never high together.
- Port A only, back-to-back words 0x01, 0x80, 0xFF: three results in order, 10 cycles apart, all with res_src=0.
- rst pulsed for 1 cycle at the 4th shift cycle of A=0x5A:
  - No res_valid.
  - busy=0 and readys recover in the cycle after rst.
  - A following B=0xA5 completes correctly.
- Stalled requester: B valid arrives during an A transfer. b_ready stays 0 until IDLE, then B is granted; the A result is unaffected.
